// File: rtl/g15_pwr_pkg.sv
// Shared types and constants for the G-15 power-up sequencer.
// Drum geometry, state encoding and the per-state output set live here.
package g15_pwr_pkg;

  typedef enum logic [2:0] {
    IDLE,
    SYNC,
    CLEAR,
    ATS,
    NT,
    OP,
    FAULT
  } pwr_state_t;

  localparam int WORDS_PER_REV = 108;
  localparam int BITS_PER_WORD = 29;
  localparam int WORD_W = 7;

  localparam int CLEAR_REVS_DEF = 2;
  localparam int NT_TIMEOUT_REVS_DEF = 8;

  function automatic int rev_width(input int a, input int b);
    return $clog2(((a > b) ? a : b) + 1);
  endfunction

  localparam int REV_W = rev_width(CLEAR_REVS_DEF, NT_TIMEOUT_REVS_DEF);

  typedef struct packed {
    logic clear;
    logic no_clear;
    logic ats;
    logic nt;
    logic op;
    logic no_op;
    logic busy;
    logic fault;
  } pwr_out_t;

  // Output levels held while in a state; the pairs stay complementary in all states.
  function automatic pwr_out_t decode(input pwr_state_t s);
    pwr_out_t o;
    o = '0;
    o.no_clear = 1'b1;
    o.no_op = 1'b1;
    case (s)
      SYNC:  o.busy = 1'b1;
      CLEAR: begin
        o.clear = 1'b1;
        o.no_clear = 1'b0;
        o.busy = 1'b1;
      end
      ATS: begin
        o.ats = 1'b1;
        o.busy = 1'b1;
      end
      NT: begin
        o.nt = 1'b1;
        o.busy = 1'b1;
      end
      OP: begin
        o.op = 1'b1;
        o.no_op = 1'b0;
      end
      FAULT: o.fault = 1'b1;
      default: ;
    endcase
    return o;
  endfunction

endpackage

// File: rtl/g15_word_rev_ctr.sv
// Word-within-revolution counter (0..107) plus revolution counter.
// Advances on each T0; rev_tick marks the T0 that completes a revolution.
module g15_word_rev_ctr
  import g15_pwr_pkg::*;
#(
  parameter int REVW = REV_W
) (
  input  logic            CLOCK,
  input  logic            rst,
  input  logic            clr,
  input  logic            inc,
  output logic [REVW-1:0] rev_cnt,
  output logic            rev_tick
);

  logic [WORD_W-1:0] word_cnt;

  assign rev_tick = inc && !clr && (word_cnt == WORD_W'(WORDS_PER_REV - 1));

  always_ff @(posedge CLOCK or negedge rst) begin
    if (!rst) begin
      word_cnt <= '0;
      rev_cnt  <= '0;
    end else if (clr) begin
      word_cnt <= '0;
      rev_cnt  <= '0;
    end else if (inc) begin
      if (rev_tick) begin
        word_cnt <= '0;
        rev_cnt  <= rev_cnt + 1'b1;
      end else begin
        word_cnt <= word_cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/g15_pwr_seq.sv
// G-15 power-up sequencer: drum-aligned memory clear, tape start, number-track
// load, then operate. Outputs are registered from the next-state decode.
//
//   state | meaning
//   IDLE  | power off, idle output set
//   SYNC  | power requested, waiting for a word start (T0)
//   CLEAR | PWR_CLEAR held for CLEAR_REVS drum revolutions
//   ATS   | automatic tape start, one word long
//   NT    | number-track write, waiting for nt_done on a T0
//   OP    | operate, held while pwr_on
//   FAULT | number-track load timed out, idle set plus fault
module g15_pwr_seq
  import g15_pwr_pkg::*;
#(
  parameter int CLEAR_REVS = 2,
  parameter int NT_TIMEOUT_REVS = 8
) (
  input  logic CLOCK,
  input  logic rst,
  input  logic T0,
  input  logic pwr_on,
  input  logic nt_done,
  output logic PWR_CLEAR,
  output logic PWR_NO_CLEAR,
  output logic PWR_ATS,
  output logic PWR_NT,
  output logic PWR_OP,
  output logic PWR_NO_OP,
  output logic busy,
  output logic fault
);

  localparam int RW = rev_width(CLEAR_REVS, NT_TIMEOUT_REVS);
  localparam logic [RW-1:0] CLEAR_LAST = RW'(CLEAR_REVS - 1);
  localparam logic [RW-1:0] NT_LAST = RW'(NT_TIMEOUT_REVS - 1);
  localparam pwr_out_t IDLE_OUT = decode(IDLE);

  pwr_state_t state, state_nxt;
  pwr_out_t out_q;
  logic ctr_clr;
  logic rev_tick;
  logic [RW-1:0] rev_cnt;

  // Counters only run while timing a clear or a number-track load.
  assign ctr_clr = !((state == CLEAR) || (state == NT));

  g15_word_rev_ctr #(.REVW(RW)) u_ctr (
    .CLOCK   (CLOCK),
    .rst     (rst),
    .clr     (ctr_clr),
    .inc     (T0),
    .rev_cnt (rev_cnt),
    .rev_tick(rev_tick)
  );

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:  if (pwr_on) state_nxt = SYNC;
      SYNC:  if (T0) state_nxt = CLEAR;
      CLEAR: if (rev_tick && (rev_cnt == CLEAR_LAST)) state_nxt = ATS;
      ATS:   if (T0) state_nxt = NT;
      NT: begin
        if (T0 && nt_done) state_nxt = OP;
        else if (rev_tick && (rev_cnt == NT_LAST)) state_nxt = FAULT;
      end
      OP:    state_nxt = OP;
      FAULT: state_nxt = FAULT;
      default: state_nxt = IDLE;
    endcase
    if (!pwr_on) state_nxt = IDLE;
  end

  always_ff @(posedge CLOCK or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
      out_q <= IDLE_OUT;
    end else begin
      state <= state_nxt;
      out_q <= decode(state_nxt);
    end
  end

  assign PWR_CLEAR    = out_q.clear;
  assign PWR_NO_CLEAR = out_q.no_clear;
  assign PWR_ATS      = out_q.ats;
  assign PWR_NT       = out_q.nt;
  assign PWR_OP       = out_q.op;
  assign PWR_NO_OP    = out_q.no_op;
  assign busy         = out_q.busy;
  assign fault        = out_q.fault;

endmodule

// File: tb/tb_g15_pwr_seq.sv
// Directed bench for g15_pwr_seq: sequence timing, nt_done handling,
// timeout, pwr_on override and asynchronous reset.
module tb_g15_pwr_seq;

  logic CLOCK, rst, T0, pwr_on, nt_done;
  logic PWR_CLEAR, PWR_NO_CLEAR, PWR_ATS, PWR_NT, PWR_OP, PWR_NO_OP, busy, fault;
  logic t0_en;
  int   bt;
  int   checks = 0;
  int   errors = 0;

  localparam logic [7:0] IDLE_SET  = 8'b0100_0100;
  localparam logic [7:0] FAULT_SET = 8'b0100_0101;
  localparam int CLEAR_LEN = 6264;
  localparam int NT_TMO    = 25056;

  g15_pwr_seq dut (
    .CLOCK       (CLOCK),
    .rst         (rst),
    .T0          (T0),
    .pwr_on      (pwr_on),
    .nt_done     (nt_done),
    .PWR_CLEAR   (PWR_CLEAR),
    .PWR_NO_CLEAR(PWR_NO_CLEAR),
    .PWR_ATS     (PWR_ATS),
    .PWR_NT      (PWR_NT),
    .PWR_OP      (PWR_OP),
    .PWR_NO_OP   (PWR_NO_OP),
    .busy        (busy),
    .fault       (fault)
  );

  wire [7:0] outv = {PWR_CLEAR, PWR_NO_CLEAR, PWR_ATS, PWR_NT, PWR_OP, PWR_NO_OP, busy, fault};

  initial begin
    CLOCK = 1'b0;
    forever #5 CLOCK = ~CLOCK;
  end

  // Word-start pulse: one CLOCK high every 29.
  initial begin
    T0 = 1'b0;
    bt = 0;
    forever begin
      @(negedge CLOCK);
      T0 = t0_en && (bt == 28);
      bt = (bt == 28) ? 0 : bt + 1;
    end
  end

  always @(negedge CLOCK) begin
    checks++;
    if (PWR_CLEAR === PWR_NO_CLEAR || PWR_OP === PWR_NO_OP) begin
      errors++;
      $display("FAIL pair_complement: got CLEAR/NO_CLEAR=%b%b OP/NO_OP=%b%b, need complementary at %0t",
               PWR_CLEAR, PWR_NO_CLEAR, PWR_OP, PWR_NO_OP, $time);
    end
  end

  function automatic logic sel_out(input int s);
    return outv[7-s];
  endfunction

  task automatic wait_high(input int s, input int bound, output bit ok);
    int n = 0;
    while (sel_out(s) !== 1'b1 && n < bound) begin
      @(negedge CLOCK);
      n++;
    end
    ok = (sel_out(s) === 1'b1);
  endtask

  task automatic count_high(input int s, input int bound, output int n);
    n = 0;
    while (sel_out(s) === 1'b1 && n < bound) begin
      n++;
      @(negedge CLOCK);
    end
  endtask

  task automatic test_reset();
    rst = 1'b0; pwr_on = 1'b1; nt_done = 1'b0; t0_en = 1'b1;
    repeat (3) @(negedge CLOCK);
    checks++;
    if (outv !== IDLE_SET) begin
      errors++; $display("FAIL reset_outputs: got %b need %b", outv, IDLE_SET);
    end
  endtask

  task automatic test_power_up();
    bit ok; int n;
    rst = 1'b1;
    wait_high(0, 100, ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL clear_start: got no PWR_CLEAR need rise within 100"); end
    checks++;
    if ({PWR_NO_CLEAR, busy} !== 2'b01) begin
      errors++; $display("FAIL clear_levels: got NO_CLEAR,busy=%b need 01", {PWR_NO_CLEAR, busy});
    end
    count_high(0, 7000, n);
    checks++;
    if (n != CLEAR_LEN) begin errors++; $display("FAIL clear_len: got %0d need %0d", n, CLEAR_LEN); end
    checks++;
    if (PWR_ATS !== 1'b1) begin errors++; $display("FAIL ats_after_clear: got %b need 1", PWR_ATS); end
    count_high(2, 100, n);
    checks++;
    if (n != 29) begin errors++; $display("FAIL ats_len: got %0d need 29", n); end
    checks++;
    if ({PWR_NT, busy} !== 2'b11) begin
      errors++; $display("FAIL nt_rise: got NT,busy=%b need 11", {PWR_NT, busy});
    end
  endtask

  task automatic test_nt_done();
    int n = 0;
    while (PWR_NT === 1'b1 && n < 600) begin
      if (n == 500) nt_done = 1'b1;
      n++;
      @(negedge CLOCK);
    end
    checks++;
    if (n != 522) begin errors++; $display("FAIL nt_done_len: got %0d need 522", n); end
    checks++;
    if ({PWR_OP, PWR_NO_OP, busy, fault} !== 4'b1000) begin
      errors++; $display("FAIL op_levels: got OP,NO_OP,busy,fault=%b need 1000", {PWR_OP, PWR_NO_OP, busy, fault});
    end
    nt_done = 1'b0;
  endtask

  task automatic test_timeout();
    bit ok; int n = 0;
    pwr_on = 1'b0;
    @(negedge CLOCK);
    checks++;
    if (outv !== IDLE_SET) begin errors++; $display("FAIL op_drop: got %b need %b", outv, IDLE_SET); end
    pwr_on = 1'b1;
    wait_high(3, 7000, ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL reach_nt_tmo: got no PWR_NT need rise"); end
    // A one-CLOCK nt_done pulse between word starts must be ignored.
    while (PWR_NT === 1'b1 && n < 26000) begin
      if (n == 10) nt_done = 1'b1;
      if (n == 11) nt_done = 1'b0;
      n++;
      @(negedge CLOCK);
    end
    checks++;
    if (n != NT_TMO) begin errors++; $display("FAIL nt_timeout_len: got %0d need %0d", n, NT_TMO); end
    checks++;
    if (outv !== FAULT_SET) begin errors++; $display("FAIL fault_levels: got %b need %b", outv, FAULT_SET); end
    repeat (40) @(negedge CLOCK);
    checks++;
    if (outv !== FAULT_SET) begin errors++; $display("FAIL fault_hold: got %b need %b", outv, FAULT_SET); end
    pwr_on = 1'b0;
    @(negedge CLOCK);
    checks++;
    if (outv !== IDLE_SET) begin errors++; $display("FAIL fault_exit: got %b need %b", outv, IDLE_SET); end
  endtask

  task automatic test_same_t0();
    bit ok; int n = 0;
    pwr_on = 1'b1;
    wait_high(0, 100, ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL restart_clear: got no PWR_CLEAR need rise"); end
    wait_high(3, 7000, ok);
    while (PWR_NT === 1'b1 && n < 26000) begin
      if (n == 25050) nt_done = 1'b1;
      n++;
      @(negedge CLOCK);
    end
    checks++;
    if (n != NT_TMO) begin errors++; $display("FAIL same_t0_len: got %0d need %0d", n, NT_TMO); end
    checks++;
    if ({PWR_OP, fault} !== 2'b10) begin
      errors++; $display("FAIL same_t0_op: got OP,fault=%b need 10", {PWR_OP, fault});
    end
    nt_done = 1'b0;
  endtask

  task automatic test_drop_mid_clear();
    bit ok; int n;
    pwr_on = 1'b0;
    @(negedge CLOCK);
    pwr_on = 1'b1;
    wait_high(0, 100, ok);
    repeat (50 * 29) @(negedge CLOCK);
    pwr_on = 1'b0;
    @(negedge CLOCK);
    checks++;
    if ({PWR_CLEAR, PWR_NO_CLEAR, busy} !== 3'b010) begin
      errors++; $display("FAIL mid_clear_drop: got CLEAR,NO_CLEAR,busy=%b need 010", {PWR_CLEAR, PWR_NO_CLEAR, busy});
    end
    pwr_on = 1'b1;
    wait_high(0, 100, ok);
    count_high(0, 7000, n);
    checks++;
    if (n != CLEAR_LEN) begin errors++; $display("FAIL reclear_len: got %0d need %0d", n, CLEAR_LEN); end
  endtask

  task automatic test_async_reset();
    bit ok;
    wait_high(3, 100, ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL reach_nt_rst: got no PWR_NT need rise"); end
    repeat (100) @(negedge CLOCK);
    #2 rst = 1'b0;
    #1;
    checks++;
    if (outv !== IDLE_SET) begin errors++; $display("FAIL async_reset: got %b need %b", outv, IDLE_SET); end
    @(negedge CLOCK);
    rst = 1'b1;
    wait_high(0, 40, ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL post_reset_clear: got no PWR_CLEAR need rise within 40"); end
  endtask

  initial begin
    test_reset();
    test_power_up();
    test_nt_done();
    test_timeout();
    test_same_t0();
    test_drop_mid_clear();
    test_async_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/g15_pwr_seq.md
# g15_pwr_seq

Power-up sequencer for the G-15: drives the six power-cycle control levels (PWR_CLEAR, PWR_NO_CLEAR, PWR_ATS, PWR_NT, PWR_OP, PWR_NO_OP) that the CPU and memory consume.

- Sequence: drum-synchronised memory clear, automatic tape start, number-track load, then operate.
- Placement: sits beside `timing`, upstream of `cpu_top`/`mem_top`/`io_top`. It replaces the static power-cycle inputs with a word-time-aligned controller.

## Interface
Parameters:
- CLEAR_REVS, 2: drum revolutions PWR_CLEAR is held.
- NT_TIMEOUT_REVS, 8: revolutions allowed for number-track load before fault.

Ports:
- CLOCK  in  1  bit-time clock (codebase drum clock).
- rst  in  1  asynchronous, active-low reset.
- T0  in  1  word-start bit time; high one CLOCK per 29-CLOCK word.
- pwr_on  in  1  host power request, level.
- nt_done  in  1  number track written (from io_top), level.
- PWR_CLEAR, PWR_NO_CLEAR  out  1  clear-memory pair, complementary.
- PWR_ATS  out  1  automatic tape start pulse.
- PWR_NT  out  1  number-track write enable.
- PWR_OP, PWR_NO_OP  out  1  operate pair, complementary.
- busy  out  1  sequence in progress.
- fault  out  1  number-track load timed out.

## Operation
States (shared enum): IDLE, SYNC, CLEAR, ATS, NT, OP, FAULT.

Idle output set:
- PWR_NO_CLEAR=1, PWR_NO_OP=1.
- All other outputs 0.
- This is also the reset value of every output.

Transitions:
- IDLE → SYNC when pwr_on=1.
- SYNC → CLEAR on the first T0.
  - Word counter and revolution counter cleared.
- CLEAR: PWR_CLEAR=1, PWR_NO_CLEAR=0, busy=1.
  - Word counter counts T0 pulses 1..108, then wraps to 0 and increments the revolution counter.
  - On the T0 that completes revolution CLEAR_REVS → ATS.
- ATS: PWR_ATS=1, busy=1, for exactly one word. Next T0 → NT; counters cleared.
- NT: PWR_NT=1, busy=1.
  - nt_done=1 sampled on a T0 → OP.
  - If revolution NT_TIMEOUT_REVS completes without nt_done → FAULT.
  - nt_done takes priority if both occur on the same T0.
- OP: PWR_OP=1, PWR_NO_OP=0; busy=0. Held while pwr_on=1.
- FAULT: idle output set plus fault=1. Exit only via pwr_on=0.

Global override: pwr_on=0 in any state → IDLE on the next CLOCK edge, regardless of T0, with the idle output set. This takes priority over every other transition.

Complementary pairs:
- Never both 1.
- Never both 0 outside the single state that asserts one of them.

## Timing
- All outputs registered. Changes appear the CLOCK after the sampling edge.
- State advances only on edges where T0=1, except the IDLE override and IDLE→SYNC, which are any-edge.
- PWR_CLEAR high for exactly CLEAR_REVS×108×29 CLOCKs (3132×CLEAR_REVS, i.e. 6264 at default).
- PWR_ATS high for exactly 29 CLOCKs.
- PWR_NT:
  - Asserts 29 CLOCKs after PWR_ATS rises.
  - Deasserts on the CLOCK after the first T0 with nt_done=1.
  - Otherwise deasserts at timeout: NT_TIMEOUT_REVS×3132 CLOCKs (25056 at default).
- nt_done is sampled only on T0. nt_done pulses that fall between T0s are ignored.
- Asynchronous reset mid-sequence: outputs drop to the idle set immediately; counters zeroed.
- After rst deassertion with pwr_on=1: IDLE→SYNC on the first edge, then waits for T0.
- T0 held high on consecutive CLOCKs counts each edge. This is illegal stimulus; no protection required.

## Structure
- Package g15_pwr_pkg:
  - pwr_state_t enum.
  - WORDS_PER_REV=108, BITS_PER_WORD=29.
  - Counter width constants via $clog2 of max(CLEAR_REVS, NT_TIMEOUT_REVS)+1.
- One sub-module, g15_word_rev_ctr:
  - 7-bit word counter wrapping at 108, plus revolution counter.
  - Synchronous clear, increment on T0, rev_tick output on wrap.
- Top-level g15_pwr_seq: FSM plus registered output decode.

## Test plan
- Reset with pwr_on=1 and T0 every 29 CLOCKs → first T0 enters CLEAR; PWR_CLEAR high 6264 CLOCKs; PWR_ATS high 29; PWR_NT rises 29 CLOCKs after ATS.
- nt_done=1 raised 500 CLOCKs into NT → PWR_NT falls and PWR_OP=1/PWR_NO_OP=0 on the CLOCK after the next T0; busy=0.
- nt_done held 0 → fault=1 after 25056 CLOCKs in NT; all PWR outputs at the idle set; pwr_on=0 then 1 restarts from SYNC.
- pwr_on dropped mid-CLEAR at word 50 → next CLOCK PWR_CLEAR=0, PWR_NO_CLEAR=1, busy=0; re-raise → full 6264-CLOCK clear again.
- rst asserted asynchronously during NT (between CLOCK edges) → outputs at the idle set before the next edge.
- nt_done and timeout wrap on the same T0 → OP, fault stays 0.
- Every cycle, assert PWR_CLEAR≠PWR_NO_CLEAR and PWR_OP≠PWR_NO_OP.
